// File: rtl/loader_defs.sv
// ----------------------------------------------------------------------------
// loader_defs
//   Shared definitions for the instruction memory boot loader:
//   - state_e      : 3-bit loader state encoding
//   - LANE_B0..B3  : byte-lane indices inside a little-endian 32-bit word
//   - csum_add     : 8-bit wrapping checksum accumulate
//   - word_to_byte_addr : word index to word-aligned byte address
//   - is_rx_state  : states in which the loader accepts stream bytes
// ----------------------------------------------------------------------------
package loader_defs;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_e;

    // Byte k of a word lands in bits [8k+7:8k]
    localparam logic [1:0] LANE_B0 = 2'd0;
    localparam logic [1:0] LANE_B1 = 2'd1;
    localparam logic [1:0] LANE_B2 = 2'd2;
    localparam logic [1:0] LANE_B3 = 2'd3;

    // Checksum is the plain 8-bit sum of payload bytes, wrapping mod 256
    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] data);
        return sum + data;
    endfunction

    // Instruction memory is word organised; the write port takes byte addresses
    function automatic logic [31:0] word_to_byte_addr(input logic [31:0] idx);
        return idx << 2;
    endfunction

    // Only these states own the byte stream
    function automatic logic is_rx_state(input state_e s);
        return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/instr_mem_loader_byte_to_word.sv
// ----------------------------------------------------------------------------
// byte_to_word
//   Little-endian 4-byte assembler. Bytes 0..2 of a word are held in a
//   24-bit buffer; the 4th byte is combined directly from the input so the
//   finished word is available in the same cycle it is accepted, which lets
//   the parent register it with a single cycle of latency.
//
// Ports
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   clr       : synchronous clear of lane counter and buffer (new load)
//   byte_en   : a byte is accepted this cycle
//   byte_in   : the accepted byte
//   word_out  : {byte_in, buffered bytes 2..0}; meaningful when word_done=1
//   word_done : the byte accepted this cycle is byte 3 of a word
// ----------------------------------------------------------------------------
module byte_to_word
    import loader_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_out,
    output logic        word_done
);

    logic [1:0]  lane_q;
    logic [1:0]  lane_d;
    logic [23:0] buf_q;
    logic [23:0] buf_d;

    // Next lane/buffer: place the incoming byte in its lane, wrap after lane 3
    always_comb begin
        lane_d = lane_q;
        buf_d  = buf_q;
        if (clr) begin
            lane_d = LANE_B0;
            buf_d  = 24'd0;
        end else if (byte_en) begin
            case (lane_q)
                LANE_B0: buf_d[7:0]   = byte_in;
                LANE_B1: buf_d[15:8]  = byte_in;
                LANE_B2: buf_d[23:16] = byte_in;
                LANE_B3: buf_d        = 24'd0;
                default: buf_d        = buf_q;
            endcase
            lane_d = lane_q + 2'd1;
        end else begin
            lane_d = lane_q;
            buf_d  = buf_q;
        end
    end

    // Lane counter and partial-word buffer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= LANE_B0;
            buf_q  <= 24'd0;
        end else begin
            lane_q <= lane_d;
            buf_q  <= buf_d;
        end
    end

    assign word_out  = {byte_in, buf_q};
    assign word_done = byte_en && !clr && (lane_q == LANE_B3);

endmodule

// File: rtl/instr_mem_loader.sv
// ----------------------------------------------------------------------------
// instr_mem_loader
//   Boot-time loader: holds the CPU, parses a framed byte stream
//   (4-byte LE length N, N LE payload words, 1 checksum byte) and writes the
//   payload words into the instruction memory at byte address index*4.
//   The checksum is the 8-bit wrapping sum of the payload bytes only.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   start      : one-cycle pulse, honoured in IDLE, DONE and ERR
//   byte_valid : source presents byte_data
//   byte_data  : stream byte
//   byte_ready : loader accepts a byte (high exactly in LEN, DATA, CSUM)
//   wr_en      : one-cycle instruction memory write strobe
//   wr_addr    : word-aligned byte address of the write
//   wr_data    : assembled little-endian word
//   cpu_hold   : CPU held in reset/stall while high
//   done       : image loaded and checksum verified
//   error      : load aborted (oversize length or bad checksum)
// All outputs are registered.
// ----------------------------------------------------------------------------
module instr_mem_loader
    import loader_defs::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MEM_SIZE   = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam logic [31:0] MEM_SIZE_W = 32'(MEM_SIZE);

    state_e                state_q;
    state_e                state_d;
    logic [31:0]           word_cnt_q;
    logic [31:0]           word_cnt_d;
    logic [31:0]           word_idx_q;
    logic [31:0]           word_idx_d;
    logic [7:0]            csum_q;
    logic [7:0]            csum_d;

    logic                  byte_ready_q;
    logic                  byte_ready_d;
    logic                  wr_en_q;
    logic                  wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [ADDR_WIDTH-1:0] wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [DATA_WIDTH-1:0] wr_data_d;
    logic                  cpu_hold_q;
    logic                  cpu_hold_d;
    logic                  done_q;
    logic                  done_d;
    logic                  error_q;
    logic                  error_d;

    logic                  accept_s;
    logic                  asm_en_s;
    logic                  asm_clr_s;
    logic [31:0]           asm_word_s;
    logic                  asm_done_s;

    // byte_ready_q tracks the registered state, so a transfer is only ever
    // seen in LEN, DATA or CSUM
    assign accept_s = byte_valid && byte_ready_q;
    // Length and payload bytes go through the assembler; the checksum byte does not
    assign asm_en_s = accept_s && ((state_q == ST_LEN) || (state_q == ST_DATA));

    byte_to_word u_byte_to_word (
        .clk       (clk),
        .rst       (rst),
        .clr       (asm_clr_s),
        .byte_en   (asm_en_s),
        .byte_in   (byte_data),
        .word_out  (asm_word_s),
        .word_done (asm_done_s)
    );

    // Next-state, counters, checksum and write-port values
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        word_idx_d = word_idx_q;
        csum_d     = csum_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        asm_clr_s  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d    = ST_LEN;
                    word_cnt_d = 32'd0;
                    word_idx_d = 32'd0;
                    csum_d     = 8'd0;
                    asm_clr_s  = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end

            ST_LEN: begin
                if (asm_done_s) begin
                    word_cnt_d = asm_word_s;
                    if (asm_word_s == 32'd0) begin
                        state_d = ST_CSUM;
                    end else if (asm_word_s > MEM_SIZE_W) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_LEN;
                end
            end

            ST_DATA: begin
                if (accept_s) begin
                    csum_d = csum_add(csum_q, byte_data);
                    if (asm_done_s) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = ADDR_WIDTH'(word_to_byte_addr(word_idx_q));
                        wr_data_d  = DATA_WIDTH'(asm_word_s);
                        word_idx_d = word_idx_q + 32'd1;
                        // word_cnt_q is non-zero here, so the subtraction cannot wrap
                        if (word_idx_q == (word_cnt_q - 32'd1)) begin
                            state_d = ST_CSUM;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end

            ST_CSUM: begin
                if (accept_s) begin
                    state_d = (byte_data == csum_q) ? ST_DONE : ST_ERR;
                end else begin
                    state_d = ST_CSUM;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags are decoded from the next state so they change on the
        // same edge as the state itself
        byte_ready_d = is_rx_state(state_d);
        cpu_hold_d   = (state_d != ST_DONE);
        done_d       = (state_d == ST_DONE);
        error_d      = (state_d == ST_ERR);
    end

    // State, counters, checksum and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            word_cnt_q   <= 32'd0;
            word_idx_q   <= 32'd0;
            csum_q       <= 8'd0;
            byte_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            word_idx_q   <= word_idx_d;
            csum_q       <= csum_d;
            byte_ready_q <= byte_ready_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Boot-time loader that fills the instruction memory from a byte stream (UART receiver or debug bridge) before the CPU fetches. It holds the CPU, parses a framed image (length word, payload words, checksum byte), assembles little-endian 32-bit words and drives the instruction memory's write port with word-aligned byte addresses. It sits between the byte source, the instruction memory write port and the CPU reset/stall logic.

## Interface
- `DATA_WIDTH`, 32: instruction word width; only 32 is supported.
- `ADDR_WIDTH`, 32: width of `wr_addr`, a byte address.
- `MEM_SIZE`, 512: instruction memory depth in words; the upper bound on the image length.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- `byte_valid` input 1: source has a byte on `byte_data`.
- `byte_data` input 8: stream byte.
- `byte_ready` output 1: loader accepts a byte this cycle; a transfer happens when `byte_valid && byte_ready`.
- `wr_en` output 1: one-cycle instruction memory write strobe.
- `wr_addr` output ADDR_WIDTH: byte address of the write, equal to word_index*4, bits [1:0]=0.
- `wr_data` output DATA_WIDTH: assembled word.
- `cpu_hold` output 1: keeps the CPU in reset/stall while high.
- `done` output 1: image loaded and verified.
- `error` output 1: load aborted.

## Operation
- States are IDLE, LEN, DATA, CSUM, DONE and ERR.
- **IDLE.** `start` clears the word/byte counters and the checksum, then moves to LEN.
- **LEN.** Accepts 4 bytes, little-endian, forming the word count N. After the 4th byte:
  - N == 0 goes to CSUM.
  - N > MEM_SIZE goes to ERR.
  - Otherwise goes to DATA.
- **DATA.** Accepts N*4 bytes.
  - Byte k of a word (k = 0..3) lands in bits [8k+7:8k].
  - When byte 3 is accepted, the word is registered to `wr_data`, `wr_addr` = word_index<<2, and `wr_en` pulses.
  - word_index then increments.
  - After word N-1 the state goes to CSUM.
- **CSUM.** Accepts 1 byte.
  - The checksum is the 8-bit sum, mod 256, of all N*4 payload bytes; length bytes are excluded.
  - Match goes to DONE; mismatch goes to ERR.
- **DONE.** `done`=1 and `cpu_hold`=0. Both hold until `rst` or `start`.
- **ERR.** `error`=1 and `cpu_hold`=1. Both hold until `rst` or `start`.
- `start` in DONE or ERR clears `done`/`error`, reasserts `cpu_hold` and enters LEN the next cycle.
- `start` in LEN, DATA or CSUM is ignored.
- `byte_ready` = 1 exactly in LEN, DATA and CSUM. It does not depend on `byte_valid`. The source may stall arbitrarily; `byte_valid` low freezes all counters.
- Words already written before ERR are not erased.

## Timing
- All outputs are registered.
- Reset values:
  - state = IDLE
  - `byte_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0
  - `cpu_hold`=1, `done`=0, `error`=0
- `start` at cycle t puts the loader in LEN, with `byte_ready`=1, at cycle t+1.
- Write latency: if byte 3 of a word is accepted at edge t, then `wr_en`=1 with valid `wr_addr`/`wr_data` during cycle t+1.
  - `wr_en` is high for exactly one cycle per word.
  - Back-to-back bytes sustain 1 byte/cycle, so `wr_en` occurs every 4 cycles at most.
- If the checksum byte is accepted at edge t, `done` or `error` rises, and `cpu_hold` falls on success, at cycle t+1.
- `rst` mid-load returns all outputs to reset values on the next edge.
  - No partial-word write is issued.
  - A pending `wr_en` is dropped.
- `start` and `rst` in the same cycle: `rst` wins.
- Counter widths:
  - word count and word_index are 32 bits; the comparison against MEM_SIZE is unsigned.
  - the byte-in-word counter is 2 bits and wraps 3->0.
  - the checksum is 8 bits and wraps.

## Structure
- A shared header/package `loader_defs` holds the state encodings (3-bit: IDLE=0, LEN=1, DATA=2, CSUM=3, DONE=4, ERR=5) and the byte-lane constants.
- One sub-module is natural: `byte_to_word`, a 4-byte little-endian shift/assemble register with a "word complete" flag. LEN and DATA both reuse it.
- The FSM, counters and checksum live in `instr_mem_loader`.

## Test plan
- **2-word load.** Stream 02 00 00 00, 13 05 10 00, 93 05 20 00, then checksum 0xE0 (sum of the payload bytes mod 256).
  - Expect `wr_en` at addr 0x0 with 0x00100513.
  - Expect `wr_en` at addr 0x4 with 0x00200593.
  - Expect `done`=1 and `cpu_hold`=0.
- **Empty image.** Stream 00 00 00 00, 00 -> no `wr_en`, `done`=1. Stream 00 00 00 00, 01 -> `error`=1.
- **Oversize length.** N=513 with MEM_SIZE=512 -> `error`=1 after the 4th length byte, `byte_ready`=0, no writes, `cpu_hold`=1.
- **Bad checksum.** Use the 2-word image with checksum 0xE1 -> both words are written, `error`=1, `cpu_hold`=1. A following `start` plus the correct image -> `done`=1.
- **Backpressure gaps.** Deassert `byte_valid` for random 0-5 cycles between bytes -> write sequence and data are identical to back-to-back delivery, with exactly one `wr_en` per word.
- **Reset mid-load.** Assert `rst` after 6 payload bytes -> the next cycle shows reset values on every output, and no write to addr 0x4. `start` ignored mid-load: a pulse in DATA leaves counters unchanged.
